cdb_arbiter: RTL and testbench

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter_pkg.sv | 30 +++
 rtl/cdb_arbiter_rr_pick.sv | 46 ++++
 rtl/cdb_arbiter.sv | 110 +++++++++++
 tb/tb_cdb_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cdb_arbiter_pkg
//  Description : Shared types and constants for the common-data-bus arbiter:
//                ROB tag width, default requester count, broadcast bus
//                struct and a tag-match helper for CDB snoopers.
//  Revision    : 1.0  initial release
// ============================================================================
package cdb_arbiter_pkg;

    // Width of a reorder-buffer tag carried on the broadcast bus
    localparam int ROB_WIDTH = 6;

    // Default number of requesters sharing the bus
    localparam int N_CDB_REQ = 4;

    // Registered broadcast bus
    typedef struct packed {
        logic                 valid;
        logic [ROB_WIDTH-1:0] tag;
        logic [31:0]          data;
    } cdb_t;

    // True when the bus carries a valid result for the given tag
    function automatic logic tag_match(input cdb_t bus, input logic [ROB_WIDTH-1:0] tag);
        return bus.valid && (bus.tag == tag);
    endfunction

endpackage : cdb_arbiter_pkg
`default_nettype wire

// File: rtl/cdb_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Rotate-and-pick: returns a one-hot grant for the first set
//                request bit found searching from i_ptr upward (mod N_REQ).
//                With i_ptr tied to zero this is plain lowest-index priority.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int PTR_W = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N_REQ-1:0] o_grant
);

    logic [2*N_REQ-1:0] w_req_dbl;
    logic [N_REQ-1:0]   w_req_rot;
    logic [N_REQ-1:0]   w_gnt_rot;
    logic [2*N_REQ-1:0] w_gnt_dbl;

    // Rotate requests right by ptr so the search always starts at bit 0
    always_comb begin
        w_req_dbl = {i_req, i_req} >> i_ptr;
        w_req_rot = w_req_dbl[N_REQ-1:0];
    end

    // Lowest set bit of the rotated vector wins
    always_comb begin
        w_gnt_rot = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_req_rot[i] && (w_gnt_rot == '0)) begin
                w_gnt_rot[i] = 1'b1;
            end
        end
    end

    // Rotate the grant back left by ptr; the upper half holds the wrapped result
    always_comb begin
        w_gnt_dbl = {w_gnt_rot, w_gnt_rot} << i_ptr;
        o_grant   = w_gnt_dbl[2*N_REQ-1:N_REQ];
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : cdb_arbiter
//  Description : Common-data-bus arbiter. Grants at most one valid requester
//                per cycle and broadcasts its tag/data on a registered bus
//                one cycle later. Flush and reset suppress all grants.
//                Macro CDB_ROUND_ROBIN_EN selects round-robin arbitration;
//                without it, lowest valid index wins and no pointer exists.
//  Revision    : 1.0  initial release
// ============================================================================
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int N_REQ = N_CDB_REQ
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                flush,
    input  logic [N_REQ-1:0]                    req_valid,
    input  logic [N_REQ-1:0][ROB_WIDTH-1:0]     req_tag,
    input  logic [N_REQ-1:0][31:0]              req_data,
    output logic [N_REQ-1:0]                    req_ready,
    output cdb_t                                cdb
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]     w_req_eff;
    logic [N_REQ-1:0]     w_grant;
    logic                 w_any;
    logic [PTR_W-1:0]     w_ptr;
    logic [ROB_WIDTH-1:0] w_sel_tag;
    logic [31:0]          w_sel_data;
    cdb_t                 r_cdb;

    // Flush and reset mask every request so nothing can be accepted
    assign w_req_eff = req_valid & {N_REQ{~(flush | reset)}};

`ifdef CDB_ROUND_ROBIN_EN
    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_gnt_idx;

    // Binary index of the granted requester
    always_comb begin
        w_gnt_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_grant[i]) begin
                w_gnt_idx = PTR_W'(i);
            end
        end
    end

    // Pointer moves one past the winner, wrapping at N_REQ; holds otherwise
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (w_any) begin
            if (w_gnt_idx == PTR_W'(N_REQ - 1)) begin
                r_ptr <= '0;
            end else begin
                r_ptr <= w_gnt_idx + 1'b1;
            end
        end
    end

    assign w_ptr = r_ptr;
`else
    // Search always starts at requester 0: fixed lowest-index priority
    assign w_ptr = '0;
`endif

    rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .i_req   (w_req_eff),
        .i_ptr   (w_ptr),
        .o_grant (w_grant)
    );

    assign w_any     = |w_grant;
    assign req_ready = w_grant;

    // One-hot AND-OR mux of the winner's tag and data
    always_comb begin
        w_sel_tag  = '0;
        w_sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_sel_tag  = w_sel_tag  | (req_tag[i]  & {ROB_WIDTH{w_grant[i]}});
            w_sel_data = w_sel_data | (req_data[i] & {32{w_grant[i]}});
        end
    end

    // Broadcast register: load on grant, otherwise drop valid and keep payload
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cdb <= '0;
        end else if (w_any) begin
            r_cdb.valid <= 1'b1;
            r_cdb.tag   <= w_sel_tag;
            r_cdb.data  <= w_sel_data;
        end else begin
            r_cdb.valid <= 1'b0;
        end
    end

    assign cdb = r_cdb;

endmodule : cdb_arbiter
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cdb_arbiter
//  Description : Self-checking bench for cdb_arbiter (N_REQ=4). Works with
//                or without CDB_ROUND_ROBIN_EN defined.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int N = 4;

    logic                           clk;
    logic                           reset;
    logic                           flush;
    logic [N-1:0]                   req_valid;
    logic [N-1:0][ROB_WIDTH-1:0]    req_tag;
    logic [N-1:0][31:0]             req_data;
    logic [N-1:0]                   req_ready;
    cdb_t                           cdb;

    int n_chk = 0;
    int n_err = 0;

    cdb_arbiter #(.N_REQ(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .req_valid (req_valid),
        .req_tag   (req_tag),
        .req_data  (req_data),
        .req_ready (req_ready),
        .cdb       (cdb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: who should win this cycle, and what the bus holds
    // ------------------------------------------------------------------
    int              m_ptr;
    logic            m_valid;
    logic [ROB_WIDTH-1:0] m_tag;
    logic [31:0]     m_data;
    bit              m_known = 0;

    // Winner index or -1
    function automatic int model_winner(input logic [N-1:0] v, input logic f,
                                        input logic r, input int ptr);
        if (r || f) return -1;
`ifdef CDB_ROUND_ROBIN_EN
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
`else
        for (int k = 0; k < N; k++) begin
            if (v[k]) return k;
        end
`endif
        return -1;
    endfunction

    function automatic logic [N-1:0] model_ready(input int w);
        logic [N-1:0] r;
        r = '0;
        if (w >= 0) r[w] = 1'b1;
        return r;
    endfunction

    always @(posedge clk) begin
        int w;
        w = model_winner(req_valid, flush, reset, m_ptr);
        if (reset) begin
            m_valid <= 1'b0;
            m_tag   <= '0;
            m_data  <= '0;
            m_ptr   <= 0;
            m_known <= 1;
        end else if (w >= 0) begin
            m_valid <= 1'b1;
            m_tag   <= req_tag[w];
            m_data  <= req_data[w];
            m_ptr   <= (w + 1) % N;
        end else begin
            m_valid <= 1'b0;
        end
    end

    // Compare process: every cycle once the model is anchored by reset
    always @(negedge clk) begin
        if (m_known) begin
            chk("model_ready", 64'(req_ready),
                64'(model_ready(model_winner(req_valid, flush, reset, m_ptr))));
            chk("model_cdb_valid", 64'(cdb.valid), 64'(m_valid));
            chk("model_cdb_tag",   64'(cdb.tag),   64'(m_tag));
            chk("model_cdb_data",  64'(cdb.data),  64'(m_data));
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        n_err++;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Directed vectors with literal expectations
    // ------------------------------------------------------------------
    initial begin
        logic [N-1:0] exp_r;
        reset     = 1'b1;
        flush     = 1'b0;
        req_valid = '0;
        req_tag   = '0;
        req_data  = '0;

        // Reset state
        req_valid = 4'b1111;
        @(negedge clk);
        chk("reset_ready", 64'(req_ready), 64'h0);
        tick();
        @(negedge clk);
        chk("reset_cdb", 64'(cdb), 64'h0);
        chk("reset_ready2", 64'(req_ready), 64'h0);
        tick();
        reset = 1'b0;
        req_valid = '0;

        // Single request
        req_valid   = 4'b0010;
        req_tag[1]  = 6'd5;
        req_data[1] = 32'hDEADBEEF;
        @(negedge clk);
        chk("single_ready", 64'(req_ready), 64'b0010);
        tick();
        req_valid = '0;
        @(negedge clk);
        chk("single_cdb", 64'(cdb), 64'({1'b1, 6'd5, 32'hDEADBEEF}));
        tick();
        @(negedge clk);
        chk("single_cdb_drop", 64'(cdb.valid), 64'h0);
        chk("single_cdb_hold_tag", 64'(cdb.tag), 64'd5);

        // Rotation / fixed priority, from reset
        tick();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            req_tag[k]  = 6'(10 + k);
            req_data[k] = 32'hA000_0000 + 32'(k);
        end
`ifdef CDB_ROUND_ROBIN_EN
        req_valid = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            exp_r = 4'b0001 << (c % 4);
            chk("rr_rotation", 64'(req_ready), 64'(exp_r));
            tick();
        end
`else
        req_valid = 4'b1110;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("fixed_prio", 64'(req_ready), 64'b0010);
            tick();
        end
`endif
        @(negedge clk);
        chk("rot_last_cdb_tag", 64'(cdb.tag), `ifdef CDB_ROUND_ROBIN_EN 64'd13 `else 64'd11 `endif);
        tick();

        // Flush collision
        req_valid = '0;
        tick();
        req_valid   = 4'b0100;
        req_tag[2]  = 6'd33;
        req_data[2] = 32'h1234_5678;
        flush = 1'b1;
        @(negedge clk);
        chk("flush_ready", 64'(req_ready), 64'h0);
        tick();
        flush = 1'b0;
        @(negedge clk);
        chk("flush_cdb_valid", 64'(cdb.valid), 64'h0);
        chk("flush_release_ready", 64'(req_ready), 64'b0100);
        tick();
        req_valid = '0;
        flush = 1'b1;
        @(negedge clk);
        chk("flush_after_grant_cdb", 64'(cdb), 64'({1'b1, 6'd33, 32'h1234_5678}));
        tick();
        flush = 1'b0;
        @(negedge clk);
        chk("flush_after_grant_drop", 64'(cdb.valid), 64'h0);
        tick();

        // Reset mid-stream
        req_valid = 4'b1111;
        tick();
        tick();
        reset = 1'b1;
        @(negedge clk);
        chk("midreset_ready", 64'(req_ready), 64'h0);
        tick();
        reset = 1'b0;
        req_valid = 4'b1110;
        @(negedge clk);
        chk("midreset_cdb", 64'(cdb), 64'h0);
        chk("midreset_first", 64'(req_ready), 64'b0010);
        tick();
        req_valid = '0;
        tick();

        // Back-pressure hold: requesters 0 and 3
        do_reset();
        req_valid = 4'b0001;
        req_tag[0] = 6'd7;  req_data[0] = 32'h0000_00AA;
        tick();
        req_valid = 4'b1001;
        req_tag[3] = 6'd9;  req_data[3] = 32'h0000_00BB;
`ifdef CDB_ROUND_ROBIN_EN
        exp_r = 4'b1000;
`else
        exp_r = 4'b0001;
`endif
        @(negedge clk);
        chk("bp_first", 64'(req_ready), 64'(exp_r));
        tick();
        req_valid = 4'b1001 & ~exp_r;
        @(negedge clk);
        chk("bp_second", 64'(req_ready), 64'(req_valid));
        chk("bp_cdb1_tag", 64'(cdb.tag), (exp_r == 4'b1000) ? 64'd9 : 64'd7);
        tick();
        req_valid = '0;
        @(negedge clk);
        chk("bp_cdb2_tag", 64'(cdb.tag), (exp_r == 4'b1000) ? 64'd7 : 64'd9);
        tick();

        // Mixed traffic, checked by the model only
        for (int c = 0; c < 40; c++) begin
            req_valid = 4'($urandom_range(0, 15));
            flush     = ($urandom_range(0, 7) == 0);
            for (int k = 0; k < 4; k++) begin
                req_tag[k]  = 6'($urandom);
                req_data[k] = $urandom;
            end
            tick();
        end
        flush = 1'b0;
        req_valid = '0;
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_cdb_arbiter
`default_nettype wire
